// File: rtl/mp_pipe.sv
// rtl/mp_pipe.sv - two-stage register-file ALU pipeline (EX, OUT) with EX-result bypass into operand fetch
module mp_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instruction,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_err
);
  localparam int NREG    = 1 << ADDR_W;
  localparam int IMM_LSB = 6 + 3 * ADDR_W;
  localparam int IMM_W   = 32 - IMM_LSB;

  localparam logic [5:0] OP_ADD = 6'd1;
  localparam logic [5:0] OP_XOR = 6'd2;
  localparam logic [5:0] OP_OR  = 6'd3;
  localparam logic [5:0] OP_MIN = 6'd4;
  localparam logic [5:0] OP_AND = 6'd5;
  localparam logic [5:0] OP_SUB = 6'd6;
  localparam logic [5:0] OP_MAX = 6'd7;
  localparam logic [5:0] OP_NEG = 6'd8;
  localparam logic [5:0] OP_AVG = 6'd11;
  localparam logic [5:0] OP_ABS = 6'd13;
  localparam logic [5:0] OP_NOT = 6'd15;
  localparam logic [5:0] OP_LDI = 6'd16;

  logic [5:0]        in_op;
  logic [ADDR_W-1:0] in_src1, in_src2, in_dst;
  logic [IMM_W-1:0]  in_imm;
  logic [DATA_W-1:0] imm_ext;

  assign in_op   = instruction[5:0];
  assign in_src1 = instruction[6 +: ADDR_W];
  assign in_src2 = instruction[6 + ADDR_W +: ADDR_W];
  assign in_dst  = instruction[6 + 2 * ADDR_W +: ADDR_W];
  assign in_imm  = instruction[31:IMM_LSB];
  assign imm_ext = DATA_W'($signed(in_imm));

  logic [DATA_W-1:0] rf_q [NREG];

  logic              ex_valid_q;
  logic [5:0]        ex_op_q;
  logic [DATA_W-1:0] ex_a_q, ex_b_q;
  logic [ADDR_W-1:0] ex_dst_q;

  logic              out_valid_q, out_err_q;
  logic [DATA_W-1:0] out_result_q;

  logic              ex_adv, accept, op_ok, byp_ok;
  logic [DATA_W-1:0] alu_res, ex_a_d, ex_b_d;
  logic [DATA_W:0]   sum_x;
  logic signed [DATA_W-1:0] sa, sb;

  assign sa    = ex_a_q;
  assign sb    = ex_b_q;
  // Sign-extended one extra bit so the average never overflows.
  assign sum_x = {ex_a_q[DATA_W-1], ex_a_q} + {ex_b_q[DATA_W-1], ex_b_q};

  always_comb begin
    alu_res = '0;
    op_ok   = 1'b1;
    case (ex_op_q)
      OP_ADD:  alu_res = ex_a_q + ex_b_q;
      OP_XOR:  alu_res = ex_a_q ^ ex_b_q;
      OP_OR:   alu_res = ex_a_q | ex_b_q;
      OP_MIN:  alu_res = (sa < sb) ? ex_a_q : ex_b_q;
      OP_AND:  alu_res = ex_a_q & ex_b_q;
      OP_SUB:  alu_res = ex_a_q - ex_b_q;
      OP_MAX:  alu_res = (sa > sb) ? ex_a_q : ex_b_q;
      OP_NEG:  alu_res = -ex_a_q;
      OP_AVG:  alu_res = DATA_W'(sum_x >> 1);
      OP_ABS:  alu_res = ex_a_q[DATA_W-1] ? -ex_a_q : ex_a_q;
      OP_NOT:  alu_res = ~ex_a_q;
      OP_LDI:  alu_res = ex_a_q;
      default: op_ok = 1'b0;
    endcase
  end

  assign ex_adv   = ex_valid_q && (!out_valid_q || out_ready);
  assign in_ready = !reset && (!ex_valid_q || ex_adv);
  assign accept   = in_valid && in_ready;
  assign byp_ok   = ex_adv && op_ok;

  // The register being written at this edge is forwarded; LDI carries its immediate in the a slot.
  always_comb begin
    ex_a_d = (byp_ok && ex_dst_q == in_src1) ? alu_res : rf_q[in_src1];
    ex_b_d = (byp_ok && ex_dst_q == in_src2) ? alu_res : rf_q[in_src2];
    if (in_op == OP_LDI) begin
      ex_a_d = imm_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q   <= 1'b0;
      ex_op_q      <= '0;
      ex_a_q       <= '0;
      ex_b_q       <= '0;
      ex_dst_q     <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_err_q    <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        ex_valid_q <= 1'b1;
        ex_op_q    <= in_op;
        ex_a_q     <= ex_a_d;
        ex_b_q     <= ex_b_d;
        ex_dst_q   <= in_dst;
      end else if (ex_adv) begin
        ex_valid_q <= 1'b0;
      end
      if (ex_adv) begin
        out_valid_q  <= 1'b1;
        out_result_q <= alu_res;
        out_err_q    <= !op_ok;
        if (op_ok) begin
          rf_q[ex_dst_q] <= alu_res;
        end
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_err    = out_err_q;
endmodule

// File: tb/tb_mp_pipe.sv
// tb/tb_mp_pipe.sv - mp_pipe bench: directed scenarios plus random traffic against an instruction-level model
module tb_mp_pipe;
  localparam int OP_ADD = 1, OP_XOR = 2, OP_OR = 3, OP_MIN = 4, OP_AND = 5, OP_SUB = 6;
  localparam int OP_MAX = 7, OP_NEG = 8, OP_AVG = 11, OP_ABS = 13, OP_NOT = 15, OP_LDI = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_err;
  logic [31:0] instruction = '0;
  logic [31:0] out_result;
  logic        in16_valid = 1'b0, in16_ready, out16_valid, out16_ready = 1'b1, out16_err;
  logic [31:0] instr16 = '0;
  logic [15:0] out16_result;

  mp_pipe #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_err(out_err)
  );

  mp_pipe #(.DATA_W(16), .ADDR_W(4)) dut16 (
    .clk(clk), .reset(reset), .in_valid(in16_valid), .in_ready(in16_ready),
    .instruction(instr16), .out_valid(out16_valid), .out_ready(out16_ready),
    .out_result(out16_result), .out_err(out16_err)
  );

  typedef struct { logic [63:0] res; bit err; } exp_t;
  exp_t        exp_q[$];
  exp_t        exp16_q[$];
  logic [63:0] mreg [32];
  logic [63:0] mreg16 [16];
  logic [31:0] prog_q[$];
  logic [63:0] got_q[$];
  bit          gerr_q[$];
  int          gcyc_q[$];
  int checks = 0;
  int failures = 0;

  function automatic logic [63:0] wmask(int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic longint sx(logic [63:0] v, int w);
    longint t;
    t = $signed(v << (64 - w));
    return t >>> (64 - w);
  endfunction

  function automatic logic [31:0] enc(int aw, int op, int dst, int s1, int s2, int imm);
    logic [31:0] m, v;
    m = (32'd1 << aw) - 32'd1;
    v = 32'(imm) << (6 + 3 * aw);
    v = v | (32'(op) & 32'h3f) | ((32'(s1) & m) << 6) | ((32'(s2) & m) << (6 + aw))
          | ((32'(dst) & m) << (6 + 2 * aw));
    return v;
  endfunction

  // Executes one instruction in program order on the architectural register state.
  function automatic void model_issue(bit is16, logic [31:0] ins);
    int w, aw, op, s1, s2, d, ilsb;
    longint a, b, r, imm;
    logic [31:0] m;
    exp_t e;
    w    = is16 ? 16 : 32;
    aw   = is16 ? 4 : 5;
    ilsb = 6 + 3 * aw;
    m    = (32'd1 << aw) - 32'd1;
    op   = int'(ins[5:0]);
    s1   = int'((ins >> 6) & m);
    s2   = int'((ins >> (6 + aw)) & m);
    d    = int'((ins >> (6 + 2 * aw)) & m);
    a    = sx(is16 ? mreg16[s1] : mreg[s1], w);
    b    = sx(is16 ? mreg16[s2] : mreg[s2], w);
    imm  = sx(64'(ins >> ilsb), 32 - ilsb);
    e.err = 1'b0;
    case (op)
      OP_ADD:  r = a + b;
      OP_XOR:  r = a ^ b;
      OP_OR:   r = a | b;
      OP_MIN:  r = (a < b) ? a : b;
      OP_AND:  r = a & b;
      OP_SUB:  r = a - b;
      OP_MAX:  r = (a > b) ? a : b;
      OP_NEG:  r = -a;
      OP_AVG:  r = (a + b) >>> 1;
      OP_ABS:  r = (a < 0) ? -a : a;
      OP_NOT:  r = ~a;
      OP_LDI:  r = imm;
      default: begin r = 0; e.err = 1'b1; end
    endcase
    e.res = 64'(r) & wmask(w);
    if (!e.err) begin
      if (is16) mreg16[d] = e.res;
      else      mreg[d]   = e.res;
    end
    if (is16) exp16_q.push_back(e);
    else      exp_q.push_back(e);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    for (int i = 0; i < 16; i++) mreg16[i] = '0;
    exp_q.delete();
    exp16_q.delete();
  endfunction

  function automatic logic [31:0] rand_instr(int aw);
    int ops[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 11, 13, 15, 16};
    int k, op;
    k = int'($urandom_range(0, 16));
    if (k < 12)      op = ops[k];
    else if (k < 16) op = OP_LDI;
    else             op = 17 + int'($urandom_range(0, 46));
    return enc(aw, op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 2047)) - 1024);
  endfunction

  task automatic cycle(input bit is16, output bit acc, output bit ov, output bit fired,
                       output logic [63:0] res, output bit err);
    @(negedge clk);
    if (is16) begin
      acc = in16_valid && in16_ready; ov = out16_valid;
      fired = out16_valid && out16_ready; res = 64'(out16_result); err = out16_err;
      if (acc) model_issue(1'b1, instr16);
    end else begin
      acc = in_valid && in_ready; ov = out_valid;
      fired = out_valid && out_ready; res = 64'(out_result); err = out_err;
      if (acc) model_issue(1'b0, instruction);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in16_valid = 1'b0; out_ready = 1'b1; out16_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  // Streams prog_q back to back with the consumer always ready; collects outputs and their cycle index.
  task automatic run_prog(input bit is16);
    int idx, cyc;
    bit acc, ov, f, e;
    logic [63:0] r;
    idx = 0; cyc = 0;
    got_q.delete(); gerr_q.delete(); gcyc_q.delete();
    while ((idx < prog_q.size() || got_q.size() < prog_q.size()) && cyc < 2000) begin
      if (is16) begin
        in16_valid = (idx < prog_q.size());
        instr16    = (idx < prog_q.size()) ? prog_q[idx] : 32'd0;
      end else begin
        in_valid    = (idx < prog_q.size());
        instruction = (idx < prog_q.size()) ? prog_q[idx] : 32'd0;
      end
      cycle(is16, acc, ov, f, r, e);
      if (acc) idx++;
      if (f) begin got_q.push_back(r); gerr_q.push_back(e); gcyc_q.push_back(cyc); end
      cyc++;
    end
    in_valid = 1'b0; in16_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in16_valid = 1'b1;
    instruction = enc(5, OP_LDI, 1, 0, 0, 5); instr16 = enc(4, OP_LDI, 1, 0, 0, 5);
    repeat (2) begin
      @(negedge clk);
      checks += 3;
      if (in_ready !== 1'b0)   begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      if (in16_ready !== 1'b0) begin failures++; $display("FAIL reset_in16_ready got=%b exp=0", in16_ready); end
      if (out_valid !== 1'b0)  begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      @(posedge clk); #1;
    end
    reset = 1'b0; in_valid = 1'b0; in16_valid = 1'b0;
    @(negedge clk);
    checks += 5;
    if (in_ready !== 1'b1)     begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    if (in16_ready !== 1'b1)   begin failures++; $display("FAIL post_reset_in16_ready got=%b exp=1", in16_ready); end
    if (out_valid !== 1'b0)    begin failures++; $display("FAIL post_reset_out_valid got=%b exp=0", out_valid); end
    if (out_result !== 32'd0)  begin failures++; $display("FAIL post_reset_out_result got=%h exp=0", out_result); end
    if (out_err !== 1'b0)      begin failures++; $display("FAIL post_reset_out_err got=%b exp=0", out_err); end
    @(posedge clk); #1;
    model_clear();
    prog_q = '{enc(5, OP_ADD, 3, 1, 2, 0), enc(5, OP_OR, 4, 30, 31, 0), enc(5, OP_NOT, 5, 0, 0, 0)};
    run_prog(1'b0);
    checks += 4;
    if (got_q.size() != 3) begin failures++; $display("FAIL regs_zero_count got=%0d exp=3", got_q.size()); end
    else begin
      if (got_q[0] !== 64'd0) begin failures++; $display("FAIL regs_zero_add got=%h exp=0", got_q[0]); end
      if (got_q[1] !== 64'd0) begin failures++; $display("FAIL regs_zero_or got=%h exp=0", got_q[1]); end
      if (got_q[2] !== 64'hFFFF_FFFF) begin failures++; $display("FAIL regs_zero_not got=%h exp=ffffffff", got_q[2]); end
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [63:0] want[4] = '{64'd100, 64'hFFFF_FFFB, 64'd95, 64'hFFFF_FFFB};
    do_reset();
    prog_q = '{enc(5, OP_LDI, 1, 0, 0, 100), enc(5, OP_LDI, 2, 0, 0, -5),
               enc(5, OP_ADD, 3, 1, 2, 0), enc(5, OP_SUB, 4, 3, 1, 0)};
    run_prog(1'b0);
    checks++;
    if (got_q.size() != 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      checks += 2;
      if (got_q[i] !== want[i] || gerr_q[i] !== 1'b0) begin
        failures++; $display("FAIL b2b_result[%0d] got=%h err=%b exp=%h", i, got_q[i], gerr_q[i], want[i]);
      end
      if (gcyc_q[i] != 2 + i) begin
        failures++; $display("FAIL b2b_timing[%0d] got_cycle=%0d exp_cycle=%0d", i, gcyc_q[i], 2 + i);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    bit acc, ov, f, e;
    logic [63:0] r, held;
    exp_t x;
    int n;
    do_reset();
    held = '0;
    for (int c = 0; c < 12; c++) begin
      in_valid = 1'b1; instruction = rand_instr(5);
      out_ready = !(c >= 3 && c <= 5);
      cycle(1'b0, acc, ov, f, r, e);
      if (c >= 3 && c <= 5) begin
        checks += 2;
        if (acc !== 1'b0) begin failures++; $display("FAIL bp_in_ready[c%0d] got=%b exp=0", c, acc); end
        if (ov !== 1'b1)  begin failures++; $display("FAIL bp_out_valid[c%0d] got=%b exp=1", c, ov); end
        if (c == 3) held = r;
        else begin
          checks++;
          if (r !== held) begin failures++; $display("FAIL bp_held[c%0d] got=%h exp=%h", c, r, held); end
        end
      end
      if (f) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL bp_extra got=%h exp=none", r); end
        else begin
          x = exp_q.pop_front();
          if (r !== x.res || e !== x.err) begin failures++; $display("FAIL bp_order got=%h/%b exp=%h/%b", r, e, x.res, x.err); end
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b1; n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      cycle(1'b0, acc, ov, f, r, e);
      if (f) begin
        x = exp_q.pop_front(); checks++;
        if (r !== x.res || e !== x.err) begin failures++; $display("FAIL bp_drain got=%h/%b exp=%h/%b", r, e, x.res, x.err); end
      end
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL bp_lost got=%0d_pending exp=0", exp_q.size()); end
  endtask

  task automatic test_bad_opcode();
    exp_t x;
    do_reset();
    prog_q = '{enc(5, OP_LDI, 5, 0, 0, 7), enc(5, 9, 5, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 0),
               enc(5, OP_ADD, 6, 5, 0, 0)};
    run_prog(1'b0);
    checks++;
    if (got_q.size() != 3) begin failures++; $display("FAIL badop_count got=%0d exp=3", got_q.size()); end
    else begin
      checks += 2;
      if (got_q[1] !== 64'd0 || gerr_q[1] !== 1'b1) begin
        failures++; $display("FAIL badop_err got=%h/%b exp=0/1", got_q[1], gerr_q[1]);
      end
      if (got_q[2] !== 64'd7 || gerr_q[2] !== 1'b0) begin
        failures++; $display("FAIL badop_nowrite got=%h/%b exp=7/0", got_q[2], gerr_q[2]);
      end
    end
    for (int i = 0; i < got_q.size() && exp_q.size() > 0; i++) begin
      x = exp_q.pop_front(); checks++;
      if (got_q[i] !== x.res || gerr_q[i] !== x.err) begin
        failures++; $display("FAIL badop_model[%0d] got=%h/%b exp=%h/%b", i, got_q[i], gerr_q[i], x.res, x.err);
      end
    end
  endtask

  task automatic test_avg_minmax();
    logic [63:0] want[7] = '{64'd1023, 64'd1023, 64'd2046, 64'hFFFF_FFFB, 64'd1023, 64'd1023, 64'hFFFF_FFFB};
    exp_t x;
    do_reset();
    prog_q = '{enc(5, OP_LDI, 1, 0, 0, 1023), enc(5, OP_LDI, 2, 0, 0, 1023), enc(5, OP_ADD, 3, 1, 2, 0),
               enc(5, OP_LDI, 8, 0, 0, -5), enc(5, OP_AVG, 4, 1, 2, 0), enc(5, OP_MAX, 5, 1, 8, 0),
               enc(5, OP_MIN, 6, 1, 8, 0), enc(5, OP_LDI, 9, 0, 0, 1)};
    repeat (31) prog_q.push_back(enc(5, OP_ADD, 9, 9, 9, 0));
    prog_q.push_back(enc(5, OP_NOT, 9, 9, 0, 0));
    prog_q.push_back(enc(5, OP_AVG, 10, 9, 9, 0));
    run_prog(1'b0);
    checks++;
    if (got_q.size() != 41) begin failures++; $display("FAIL avg_count got=%0d exp=41", got_q.size()); end
    else begin
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (got_q[i] !== want[i]) begin failures++; $display("FAIL avg_signed[%0d] got=%h exp=%h", i, got_q[i], want[i]); end
      end
      checks++;
      if (got_q[40] !== 64'h7FFF_FFFF) begin failures++; $display("FAIL avg_max_pos got=%h exp=7fffffff", got_q[40]); end
    end
    for (int i = 0; i < got_q.size() && exp_q.size() > 0; i++) begin
      x = exp_q.pop_front(); checks++;
      if (got_q[i] !== x.res || gerr_q[i] !== x.err) begin
        failures++; $display("FAIL avg_model[%0d] got=%h/%b exp=%h/%b", i, got_q[i], gerr_q[i], x.res, x.err);
      end
    end
  endtask

  task automatic test_reset_flush();
    bit acc, ov, f, e;
    logic [63:0] r;
    do_reset();
    prog_q = '{enc(5, OP_LDI, 1, 0, 0, 5), enc(5, OP_LDI, 2, 0, 0, 6)};
    run_prog(1'b0);
    exp_q.delete();
    in_valid = 1'b1; instruction = enc(5, OP_ADD, 7, 1, 2, 0);
    cycle(1'b0, acc, ov, f, r, e);
    checks++;
    if (acc !== 1'b1) begin failures++; $display("FAIL flush_accept got=%b exp=1", acc); end
    in_valid = 1'b0; reset = 1'b1;
    cycle(1'b0, acc, ov, f, r, e);
    reset = 1'b0;
    model_clear();
    cycle(1'b0, acc, ov, f, r, e);
    checks++;
    if (ov !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b exp=0", ov); end
    prog_q = '{enc(5, OP_ADD, 8, 7, 0, 0), enc(5, OP_ADD, 9, 1, 2, 0)};
    run_prog(1'b0);
    checks++;
    if (got_q.size() != 2 || got_q[0] !== 64'd0 || got_q[1] !== 64'd0) begin
      failures++; $display("FAIL flush_regs_cleared got_n=%0d r7=%h exp=2/0", got_q.size(), got_q.size() > 0 ? got_q[0] : 64'hx);
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    bit acc, ov, f, e;
    logic [63:0] r;
    exp_t x;
    int n;
    do_reset();
    instruction = rand_instr(5);
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      cycle(1'b0, acc, ov, f, r, e);
      if (acc) instruction = rand_instr(5);
      if (f) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL rand_extra got=%h exp=none", r); end
        else begin
          x = exp_q.pop_front();
          if (r !== x.res || e !== x.err) begin failures++; $display("FAIL rand_result[c%0d] got=%h/%b exp=%h/%b", c, r, e, x.res, x.err); end
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b1; n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      cycle(1'b0, acc, ov, f, r, e);
      if (f) begin
        x = exp_q.pop_front(); checks++;
        if (r !== x.res || e !== x.err) begin failures++; $display("FAIL rand_drain got=%h/%b exp=%h/%b", r, e, x.res, x.err); end
      end
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL rand_lost got=%0d_pending exp=0", exp_q.size()); end
  endtask

  task automatic test_w16();
    exp_t x;
    do_reset();
    prog_q = '{enc(4, OP_LDI, 1, 0, 0, -1), enc(4, OP_ABS, 2, 1, 0, 0), enc(4, OP_NOT, 4, 3, 0, 0),
               enc(4, OP_LDI, 5, 0, 0, 1)};
    repeat (15) prog_q.push_back(enc(4, OP_ADD, 5, 5, 5, 0));
    prog_q.push_back(enc(4, OP_NEG, 6, 5, 0, 0));
    run_prog(1'b1);
    checks++;
    if (got_q.size() != 20) begin failures++; $display("FAIL w16_count got=%0d exp=20", got_q.size()); end
    else begin
      checks += 3;
      if (got_q[1] !== 64'd1)      begin failures++; $display("FAIL w16_abs got=%h exp=1", got_q[1]); end
      if (got_q[2] !== 64'hFFFF)   begin failures++; $display("FAIL w16_not got=%h exp=ffff", got_q[2]); end
      if (got_q[19] !== 64'h8000)  begin failures++; $display("FAIL w16_neg_min got=%h exp=8000", got_q[19]); end
    end
    for (int i = 0; i < got_q.size() && exp16_q.size() > 0; i++) begin
      x = exp16_q.pop_front(); checks++;
      if (got_q[i] !== x.res || gerr_q[i] !== x.err) begin
        failures++; $display("FAIL w16_model[%0d] got=%h/%b exp=%h/%b", i, got_q[i], gerr_q[i], x.res, x.err);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    model_clear();
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_bad_opcode();
    test_avg_minmax();
    test_reset_flush();
    test_random();
    test_w16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
